// File: rtl/elevator_request_scheduler.sv
// Elevator call latch and collective (sweep) target scheduler.
// Optional: `define EMERGENCY_CLEAR_EN to drop all calls on emergency hold.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS       = 4,
    parameter int FLOOR_W          = 2,
    parameter int DISPATCH_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door_open,
    input  logic                  stopped,
    input  logic                  emergency_stop,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  up_request,
    output logic                  down_request,
    output logic [NUM_FLOORS-1:0] pending_calls,
    output logic                  dir_up,
    output logic                  served_valid,
    output logic [FLOOR_W-1:0]    served_floor,
    output logic [2:0]            sched_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SELECT   = 3'd1;
    localparam logic [2:0] S_DISPATCH = 3'd2;
    localparam logic [2:0] S_WAIT     = 3'd3;
    localparam logic [2:0] S_DOOR     = 3'd4;
    localparam logic [2:0] S_HOLD     = 3'd5;

    localparam int CNT_W = $clog2(DISPATCH_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DISPATCH_TIMEOUT - 1);

    logic [2:0]            state;
    logic [2:0]            state_nx;
    logic [CNT_W-1:0]      wait_cnt;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic                  serve;
    logic [FLOOR_W-1:0]    serve_floor;

    logic                  ge_hit, gt_hit, le_hit, lt_hit;
    logic [FLOOR_W-1:0]    ge_idx, gt_idx, le_idx, lt_idx;
    logic                  sel_hit;
    logic                  sel_dir;
    logic [FLOOR_W-1:0]    sel_floor;

    // Nearest pending floor on each side of the car, strict and inclusive.
    always_comb begin
        ge_hit = 1'b0;
        gt_hit = 1'b0;
        le_hit = 1'b0;
        lt_hit = 1'b0;
        ge_idx = '0;
        gt_idx = '0;
        le_idx = '0;
        lt_idx = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_calls[i] && FLOOR_W'(i) >= current_floor) begin
                ge_hit = 1'b1;
                ge_idx = FLOOR_W'(i);
            end
            if (pending_calls[i] && FLOOR_W'(i) > current_floor) begin
                gt_hit = 1'b1;
                gt_idx = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_calls[i] && FLOOR_W'(i) <= current_floor) begin
                le_hit = 1'b1;
                le_idx = FLOOR_W'(i);
            end
            if (pending_calls[i] && FLOOR_W'(i) < current_floor) begin
                lt_hit = 1'b1;
                lt_idx = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        sel_hit   = 1'b0;
        sel_dir   = dir_up;
        sel_floor = target_floor;
        if (dir_up) begin
            if (ge_hit) begin
                sel_hit   = 1'b1;
                sel_floor = ge_idx;
            end else if (lt_hit) begin
                sel_hit   = 1'b1;
                sel_dir   = 1'b0;
                sel_floor = lt_idx;
            end
        end else begin
            if (le_hit) begin
                sel_hit   = 1'b1;
                sel_floor = le_idx;
            end else if (gt_hit) begin
                sel_hit   = 1'b1;
                sel_dir   = 1'b1;
                sel_floor = gt_idx;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        clear_mask  = '0;
        serve       = 1'b0;
        serve_floor = target_floor;
        case (state)
            S_IDLE: begin
                if (emergency_stop)
                    state_nx = S_HOLD;
                else if (pending_calls != '0 && stopped && !door_open)
                    state_nx = S_SELECT;
            end
            S_SELECT: begin
                if (emergency_stop) begin
                    state_nx = S_HOLD;
                end else if (!sel_hit) begin
                    state_nx = S_IDLE;
                end else if (sel_floor == current_floor) begin
                    serve                 = 1'b1;
                    serve_floor           = sel_floor;
                    clear_mask[sel_floor] = 1'b1;
                    state_nx              = S_IDLE;
                end else begin
                    state_nx = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                state_nx = emergency_stop ? S_HOLD : S_WAIT;
            end
            S_WAIT: begin
                if (emergency_stop) begin
                    state_nx = S_HOLD;
                end else if (door_open && current_floor == target_floor) begin
                    serve                    = 1'b1;
                    clear_mask[target_floor] = 1'b1;
                    state_nx                 = S_DOOR;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nx = S_DISPATCH;
                end
            end
            S_DOOR: begin
                if (!door_open)
                    state_nx = S_IDLE;
            end
            S_HOLD: begin
                if (!emergency_stop)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef EMERGENCY_CLEAR_EN
    logic enter_hold;
    assign enter_hold = (state_nx == S_HOLD) && (state != S_HOLD);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            pending_calls <= '0;
            target_floor  <= '0;
            up_request    <= 1'b0;
            down_request  <= 1'b0;
            served_valid  <= 1'b0;
            served_floor  <= '0;
            dir_up        <= 1'b1;
            wait_cnt      <= '0;
        end else begin
            state         <= state_nx;
            pending_calls <= (pending_calls | call_req) & ~clear_mask;
            up_request    <= 1'b0;
            down_request  <= 1'b0;
            served_valid  <= serve;
            if (serve)
                served_floor <= serve_floor;
            if (state == S_DISPATCH && !emergency_stop) begin
                up_request   <= (target_floor > current_floor);
                down_request <= !(target_floor > current_floor);
            end
            if (state == S_SELECT && !emergency_stop && sel_hit) begin
                target_floor <= sel_floor;
                dir_up       <= sel_dir;
            end
            if (state == S_DISPATCH)
                wait_cnt <= '0;
            else if (state == S_WAIT && state_nx == S_WAIT)
                wait_cnt <= wait_cnt + 1'b1;
`ifdef EMERGENCY_CLEAR_EN
            // Calls are dropped on entry and ignored for the whole hold.
            if (state_nx == S_HOLD)
                pending_calls <= '0;
            if (enter_hold)
                dir_up <= 1'b1;
`endif
        end
    end

    assign sched_state = state;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed, table-driven bench for elevator_request_scheduler.
// Honors EMERGENCY_CLEAR_EN when the design is built with it.
module tb_elevator_request_scheduler;

    localparam int TO = 64;

`ifdef EMERGENCY_CLEAR_EN
    localparam logic [3:0] HOLD_PEND_U = 4'h0;
    localparam logic [3:0] HOLD_PEND_E = 4'h0;
`else
    localparam logic [3:0] HOLD_PEND_U = 4'h8;
    localparam logic [3:0] HOLD_PEND_E = 4'hA;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] call_req;
    logic [1:0] current_floor;
    logic       door_open;
    logic       stopped;
    logic       emergency_stop;
    logic [1:0] target_floor;
    logic       up_request;
    logic       down_request;
    logic [3:0] pending_calls;
    logic       dir_up;
    logic       served_valid;
    logic [1:0] served_floor;
    logic [2:0] sched_state;

    int tests = 0;
    int fails = 0;

    elevator_request_scheduler #(
        .NUM_FLOORS(4),
        .FLOOR_W(2),
        .DISPATCH_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .call_req(call_req),
        .current_floor(current_floor),
        .door_open(door_open),
        .stopped(stopped),
        .emergency_stop(emergency_stop),
        .target_floor(target_floor),
        .up_request(up_request),
        .down_request(down_request),
        .pending_calls(pending_calls),
        .dir_up(dir_up),
        .served_valid(served_valid),
        .served_floor(served_floor),
        .sched_state(sched_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] call;
        logic [1:0] cur;
        logic       dr;
        logic       stp;
        logic       es;
        logic [2:0] st;
        logic [1:0] tgt;
        logic       up;
        logic       dn;
        logic [3:0] pend;
        logic       dir;
        logic       sv;
        logic [1:0] sf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [3:0] call, input logic [1:0] cur,
        input logic dr, input logic stp, input logic es,
        input logic [2:0] st, input logic [1:0] tgt,
        input logic up, input logic dn, input logic [3:0] pend,
        input logic dir, input logic sv, input logic [1:0] sf);
        vec_t v;
        v.call = call; v.cur = cur; v.dr = dr; v.stp = stp; v.es = es;
        v.st = st; v.tgt = tgt; v.up = up; v.dn = dn; v.pend = pend;
        v.dir = dir; v.sv = sv; v.sf = sf;
        return v;
    endfunction

    function automatic logic [14:0] snap();
        return {sched_state, target_floor, up_request, down_request,
                pending_calls, dir_up, served_valid, served_floor};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        call_req = '0;
        current_floor = '0;
        door_open = 1'b0;
        stopped = 1'b1;
        emergency_stop = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [14:0] exp_v;
        int n;
        int gap;
        logic seen;

        //           call cur d s e  st tgt up dn pend dir sv sf
        tbl.push_back(mk(4'h8, 0, 0, 1, 0, 0, 0, 0, 0, 4'h8, 1, 0, 0));
        tbl.push_back(mk(4'h0, 0, 0, 1, 0, 1, 0, 0, 0, 4'h8, 1, 0, 0));
        tbl.push_back(mk(4'h0, 0, 0, 1, 0, 2, 3, 0, 0, 4'h8, 1, 0, 0));
        tbl.push_back(mk(4'h0, 0, 0, 1, 0, 3, 3, 1, 0, 4'h8, 1, 0, 0));
        tbl.push_back(mk(4'h0, 0, 0, 0, 0, 3, 3, 0, 0, 4'h8, 1, 0, 0));
        tbl.push_back(mk(4'h0, 3, 1, 1, 0, 4, 3, 0, 0, 4'h0, 1, 1, 3));
        tbl.push_back(mk(4'h0, 3, 1, 1, 0, 4, 3, 0, 0, 4'h0, 1, 0, 3));
        tbl.push_back(mk(4'h0, 3, 0, 1, 0, 0, 3, 0, 0, 4'h0, 1, 0, 3));
        // sweep: up to 3 first, then reverse down to 0
        tbl.push_back(mk(4'h9, 1, 0, 1, 0, 0, 3, 0, 0, 4'h9, 1, 0, 3));
        tbl.push_back(mk(4'h0, 1, 0, 1, 0, 1, 3, 0, 0, 4'h9, 1, 0, 3));
        tbl.push_back(mk(4'h0, 1, 0, 1, 0, 2, 3, 0, 0, 4'h9, 1, 0, 3));
        tbl.push_back(mk(4'h0, 1, 0, 1, 0, 3, 3, 1, 0, 4'h9, 1, 0, 3));
        tbl.push_back(mk(4'h0, 2, 0, 0, 0, 3, 3, 0, 0, 4'h9, 1, 0, 3));
        tbl.push_back(mk(4'h0, 3, 1, 1, 0, 4, 3, 0, 0, 4'h1, 1, 1, 3));
        tbl.push_back(mk(4'h0, 3, 0, 1, 0, 0, 3, 0, 0, 4'h1, 1, 0, 3));
        tbl.push_back(mk(4'h0, 3, 0, 1, 0, 1, 3, 0, 0, 4'h1, 1, 0, 3));
        tbl.push_back(mk(4'h0, 3, 0, 1, 0, 2, 0, 0, 0, 4'h1, 0, 0, 3));
        tbl.push_back(mk(4'h0, 3, 0, 1, 0, 3, 0, 0, 1, 4'h1, 0, 0, 3));
        tbl.push_back(mk(4'h0, 0, 1, 1, 0, 4, 0, 0, 0, 4'h0, 0, 1, 0));
        tbl.push_back(mk(4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0));
        // call at the current floor: served from SELECT, no request
        tbl.push_back(mk(4'h4, 2, 0, 1, 0, 0, 0, 0, 0, 4'h4, 0, 0, 0));
        tbl.push_back(mk(4'h0, 2, 0, 1, 0, 1, 0, 0, 0, 4'h4, 0, 0, 0));
        tbl.push_back(mk(4'h0, 2, 0, 1, 0, 0, 2, 0, 0, 4'h0, 0, 1, 2));
        tbl.push_back(mk(4'h0, 2, 0, 1, 0, 0, 2, 0, 0, 4'h0, 0, 0, 2));
        // press and door-open on the same floor in one cycle
        tbl.push_back(mk(4'h2, 2, 0, 1, 0, 0, 2, 0, 0, 4'h2, 0, 0, 2));
        tbl.push_back(mk(4'h0, 2, 0, 1, 0, 1, 2, 0, 0, 4'h2, 0, 0, 2));
        tbl.push_back(mk(4'h0, 2, 0, 1, 0, 2, 1, 0, 0, 4'h2, 0, 0, 2));
        tbl.push_back(mk(4'h0, 2, 0, 1, 0, 3, 1, 0, 1, 4'h2, 0, 0, 2));
        tbl.push_back(mk(4'h2, 1, 1, 1, 0, 4, 1, 0, 0, 4'h0, 0, 1, 1));
        tbl.push_back(mk(4'h0, 1, 0, 1, 0, 0, 1, 0, 0, 4'h0, 0, 0, 1));
        // emergency in DISPATCH: hold with no pulse
        tbl.push_back(mk(4'h8, 1, 0, 1, 0, 0, 1, 0, 0, 4'h8, 0, 0, 1));
        tbl.push_back(mk(4'h0, 1, 0, 1, 0, 1, 1, 0, 0, 4'h8, 0, 0, 1));
        tbl.push_back(mk(4'h0, 1, 0, 1, 0, 2, 3, 0, 0, 4'h8, 1, 0, 1));
        tbl.push_back(mk(4'h0, 1, 0, 1, 1, 5, 3, 0, 0, HOLD_PEND_U,
                         1, 0, 1));
        tbl.push_back(mk(4'h0, 1, 0, 1, 0, 0, 3, 0, 0, HOLD_PEND_U,
                         1, 0, 1));

        do_reset();
        chk("reset_state", 32'(snap()), 32'({3'd0, 2'd0, 1'b0, 1'b0,
            4'h0, 1'b1, 1'b0, 2'd0}));

        for (int i = 0; i < tbl.size(); i++) begin
            call_req = tbl[i].call;
            current_floor = tbl[i].cur;
            door_open = tbl[i].dr;
            stopped = tbl[i].stp;
            emergency_stop = tbl[i].es;
            tick();
            exp_v = {tbl[i].st, tbl[i].tgt, tbl[i].up, tbl[i].dn,
                     tbl[i].pend, tbl[i].dir, tbl[i].sv, tbl[i].sf};
            chk($sformatf("vec%0d", i), 32'(snap()), 32'(exp_v));
        end

        // Timeout re-issue: one up pulse every TO+1 cycles.
        do_reset();
        call_req = 4'h8;
        tick();
        call_req = 4'h0;
        n = 0;
        while (!up_request && n < 20) begin
            tick();
            n++;
        end
        chk("to_first_up", 32'(up_request), 32'd1);
        chk("to_target", 32'(target_floor), 32'd3);
        seen = 1'b0;
        for (int p = 0; p < 2; p++) begin
            gap = 0;
            do begin
                tick();
                gap++;
                if (down_request) seen = 1'b1;
            end while (!up_request && gap < 3 * TO);
            chk($sformatf("to_gap%0d", p), 32'(gap), 32'(TO + 1));
        end
        chk("to_no_down", 32'(seen), 32'd0);

        // Reset mid-trip drops calls without a served pulse.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset", 32'({sched_state, pending_calls, served_valid,
            up_request, dir_up}), 32'({3'd0, 4'h0, 1'b0, 1'b0, 1'b1}));

        // Emergency stop while waiting for arrival.
        do_reset();
        call_req = 4'hA;
        tick();
        call_req = 4'h0;
        n = 0;
        while (sched_state != 3'd3 && n < 20) begin
            tick();
            n++;
        end
        chk("em_wait", 32'(sched_state), 32'd3);
        chk("em_target", 32'(target_floor), 32'd1);
        emergency_stop = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (up_request || down_request || sched_state != 3'd5)
                seen = 1'b1;
        end
        chk("em_hold_quiet", 32'(seen), 32'd0);
        chk("em_hold_pend", 32'(pending_calls), 32'(HOLD_PEND_E));
        emergency_stop = 1'b0;
        tick();
        chk("em_release", 32'({sched_state, pending_calls}),
            32'({3'd0, HOLD_PEND_E}));
`ifdef EMERGENCY_CLEAR_EN
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (up_request || down_request || sched_state != 3'd0)
                seen = 1'b1;
        end
        chk("em_stay_idle", 32'(seen), 32'd0);
`else
        n = 0;
        while (!up_request && n < 10) begin
            tick();
            n++;
        end
        chk("em_resume_up", 32'(up_request), 32'd1);
        chk("em_resume_tgt", 32'(target_floor), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/elevator_request_scheduler.md
Name: elevator_request_scheduler

Overview:
Upstream stage of ElevatorController. Latches per-floor call buttons and selects the next floor in collective (sweep) order. Drives target_floor and one-cycle up_request/down_request pulses into the controller. Clears each call when the controller opens the door at that floor.

Parameters:
NUM_FLOORS, 4, number of floors served; calls are indexed 0..NUM_FLOORS-1.
FLOOR_W, 2, width of floor numbers; must hold NUM_FLOORS-1.
DISPATCH_TIMEOUT, 64, cycles to wait in WAIT for arrival before re-issuing the request; must be ≥2.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
call_req  input  NUM_FLOORS  button presses; bit i set = call for floor i; level or pulse, OR-latched
current_floor  input  FLOOR_W  floor the car is at (same signal the controller sees)
door_open  input  1  door_open from controller
stopped  input  1  stopped from controller
emergency_stop  input  1  emergency stop (shared with controller)
target_floor  output  FLOOR_W  registered target; connects to controller target_floor
up_request  output  1  one-cycle pulse; target above current
down_request  output  1  one-cycle pulse; target below current
pending_calls  output  NUM_FLOORS  latched, unserved calls
dir_up  output  1  sweep direction; 1 = up
served_valid  output  1  one-cycle pulse when a call is cleared
served_floor  output  FLOOR_W  floor cleared; valid with served_valid
sched_state  output  3  state encoding (debug)

Behaviour:
- Reset values: pending_calls=0, target_floor=0, up_request=0, down_request=0, served_valid=0, served_floor=0, dir_up=1, timeout counter=0, state=IDLE.
- Reset mid-operation drops all pending calls with no served pulse.
- All outputs are registered.
- Latching: pending_calls <= (pending_calls | call_req) & ~clear_mask, every cycle, in every state.
  - If a set and a clear hit the same floor in the same cycle, the clear wins; the press is absorbed by the open door.
- States and encoding: IDLE=0, SELECT=1, DISPATCH=2, WAIT=3, DOOR=4, HOLD=5.
- IDLE: go to SELECT when pending_calls≠0, stopped=1, door_open=0 and emergency_stop=0.
- SELECT (1 cycle), selection rule evaluated on the registered pending_calls:
  - dir_up=1: nearest pending floor ≥ current_floor. If none, set dir_up=0 and take the nearest floor < current_floor.
  - dir_up=0: mirror of the above.
  - The result is registered into target_floor.
  - If target == current_floor: clear that bit, pulse served_valid with served_floor=target, return to IDLE, no request issued.
  - Otherwise go to DISPATCH.
- DISPATCH (1 cycle):
  - Assert up_request if target_floor > current_floor, else down_request. Never assert both.
  - Reset the timeout counter. Go to WAIT.
- WAIT: conditions evaluated in this priority order:
  1. emergency_stop=1 → HOLD.
  2. door_open=1 and current_floor==target_floor → clear the bit, pulse served_valid, go to DOOR.
  3. Counter reaches DISPATCH_TIMEOUT-1 → DISPATCH (re-issue the request).
  4. Otherwise increment the counter.
- DOOR: go to IDLE when door_open=0.
- HOLD: requests are held low. Go to IDLE the cycle after emergency_stop is sampled 0.
- emergency_stop=1 in IDLE, SELECT or DISPATCH goes to HOLD. No request pulse is issued that cycle.
- New calls arriving during WAIT never retarget mid-trip. They are picked up at the next SELECT.
- call_req bits at or above NUM_FLOORS do not exist. target_floor is always < NUM_FLOORS.

Optional Feature:
Macro: EMERGENCY_CLEAR_EN.
- Defined: entering HOLD clears all pending_calls (no served pulses) and sets dir_up=1. Calls pressed while in HOLD are ignored.
- Not defined: pending_calls are retained through HOLD and keep latching. Dispatch resumes from IDLE after the emergency clears.

Test Plan:
- Reset; current=0; pulse call_req=4'b1000 → SELECT, target_floor=3, then one-cycle up_request=1. Drive door_open=1 with current=3 → served_valid=1, served_floor=3, pending_calls=0.
- current=1, dir_up=1, pending={0,3} → target 3 (up_request) first. After serving 3: dir_up=0, target 0, down_request pulse.
- current=2, idle, call_req=4'b0100 → served_valid with served_floor=2 two cycles later; no up_request or down_request.
- Dispatch to floor 3 with no door_open for DISPATCH_TIMEOUT cycles → up_request re-pulses exactly once per timeout period.
- Pending {1,3}; emergency_stop high for 5 cycles during WAIT → HOLD, no request pulses. With EMERGENCY_CLEAR_EN: pending=0. Without it: pending={1,3} and dispatch resumes after release.
- door_open=1 at the target floor while call_req sets that same floor in the same cycle → the bit ends cleared and served_valid pulses once.
